// File: rtl/rv32_pkg.sv
// Shared RV32I types and constants for the fetch stage.
package rv32_pkg;

    // Width of one instruction word and of a fetch address.
    localparam int ILEN = 32;

    // Address the core fetches from after reset unless overridden.
    localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the instruction and the address it came from.
    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/grant/response, decoder
// valid/ready, and redirect. Signal names keep the o_/i_ view of the fetch unit.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_imem_req;
    logic [DATA_WIDTH-1:0] o_imem_addr;
    logic                  i_imem_gnt;
    logic                  i_imem_rvalid;
    logic [DATA_WIDTH-1:0] i_imem_rdata;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_instruction;
    logic [DATA_WIDTH-1:0] o_pc;
    logic                  i_redirect;
    logic [DATA_WIDTH-1:0] i_redirect_pc;
    logic                  o_misaligned;

    // Fetch unit side.
    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_valid, o_instruction, o_pc, o_misaligned,
        input  i_ready, i_redirect, i_redirect_pc
    );

    // Memory / decoder / branch-unit side.
    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_valid, o_instruction, o_pc, o_misaligned,
        output i_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush wins over push and pop.
// The head entry is read straight from storage so it is stable while not popped.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Advance a storage pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = p + PW'(1);
        end
    endfunction

    // Qualify push/pop: never pop empty, never push full unless a pop frees a slot.
    always_comb begin
        do_pop_s  = pop & (count_r != '0);
        do_push_s = push & ((count_r != CW'(DEPTH)) | do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present head entry and occupancy.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        count = count_r;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues word requests,
// buffers responses with their PC and hands them to the decoder.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect detection).
// Requests are only issued while a FIFO slot is guaranteed for the response,
// counting the slot the decoder frees this cycle.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  running_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [CW-1:0]         outstanding_r;
    logic [CW-1:0]         discard_r;

    logic                  redirect_s;
    logic [DATA_WIDTH-1:0] target_s;
    logic                  misaligned_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  req_s;
    logic                  grant_s;
    logic [CW:0]           inflight_s;
    logic [CW:0]           limit_s;
    logic [DATA_WIDTH-1:0] resp_pc_s;
    logic [CW-1:0]         fifo_count_s;
    fetch_entry_t          entry_s;
    fetch_entry_t          head_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_r;

    // Flag a redirect to a non-word address; the next aligned redirect clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_r <= 1'b0;
        end else if (redirect_s) begin
            misaligned_r <= (target_s[1:0] != 2'b00);
        end else begin
            misaligned_r <= misaligned_r;
        end
    end

    assign misaligned_s = misaligned_r;
    assign target_s     = bus.i_redirect_pc;
`else
    assign misaligned_s = 1'b0;
    assign target_s     = bus.i_redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
`endif

    // Request, pop and push decisions for this cycle.
    always_comb begin
        // Redirects before the first running cycle belong to reset and are ignored.
        redirect_s = bus.i_redirect & running_r;
        pop_s      = (fifo_count_s != '0) & bus.i_ready & ~redirect_s;
        inflight_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        limit_s    = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop_s);
        req_s      = running_r & ~redirect_s & ~misaligned_s & (inflight_s < limit_s);
        grant_s    = req_s & bus.i_imem_gnt;
        push_s     = bus.i_imem_rvalid & (discard_r == '0) & ~redirect_s;
        // Oldest in-flight request sits outstanding words behind the fetch PC.
        resp_pc_s     = pc_r - (DATA_WIDTH'(outstanding_r) << 2);
        entry_s.pc    = resp_pc_s;
        entry_s.instr = bus.i_imem_rdata;
    end

    // Fetch PC, run flag and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running_r     <= 1'b0;
            pc_r          <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            running_r <= 1'b1;
            if (redirect_s) begin
                pc_r          <= target_s;
                // Whatever is still in flight after this cycle belongs to the old stream.
                outstanding_r <= outstanding_r - CW'(bus.i_imem_rvalid);
                discard_r     <= outstanding_r - CW'(bus.i_imem_rvalid);
            end else begin
                if (grant_s) begin
                    pc_r <= pc_r + DATA_WIDTH'(4);
                end else begin
                    pc_r <= pc_r;
                end
                outstanding_r <= outstanding_r + CW'(grant_s) - CW'(bus.i_imem_rvalid);
                if (bus.i_imem_rvalid && (discard_r != '0)) begin
                    discard_r <= discard_r - CW'(1);
                end else begin
                    discard_r <= discard_r;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_s),
        .wdata (entry_s),
        .rdata (head_s),
        .count (fifo_count_s)
    );

    // Drive the bus outputs.
    always_comb begin
        bus.o_imem_req    = req_s;
        bus.o_imem_addr   = pc_r;
        bus.o_valid       = (fifo_count_s != '0);
        bus.o_instruction = head_s.instr;
        bus.o_pc          = head_s.pc;
        bus.o_misaligned  = misaligned_s;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core: owns the fetch PC, issues word requests to instruction memory over a request/grant interface, buffers returned instructions with their PC in a small FIFO, and presents them to the decoder through a valid/ready handshake. It sits directly upstream of the decoder and supersedes the free-running program counter. Branch/jump redirects flush the buffer and discard in-flight responses.

## Interface
- DATA_WIDTH, 32, instruction/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 2, buffered instructions; also max outstanding + buffered total (≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- o_imem_req  out  1  fetch request
- o_imem_addr  out  DATA_WIDTH  word address of request
- i_imem_gnt  in  1  request accepted this cycle (meaningful only with o_imem_req)
- i_imem_rvalid  in  1  response data valid; in order, ≥1 cycle after its grant
- i_imem_rdata  in  DATA_WIDTH  instruction word
- o_valid  out  1  instruction available to decoder
- i_ready  in  1  decoder accepts this cycle
- o_instruction  out  DATA_WIDTH  FIFO head instruction
- o_pc  out  DATA_WIDTH  PC of o_instruction
- i_redirect  in  1  control-flow change
- i_redirect_pc  in  DATA_WIDTH  redirect target
- o_misaligned  out  1  misaligned redirect flag (see Configuration)

## Operation
- State: fetch PC, `running` flag, FIFO (pc, instr), outstanding counter (granted, no rvalid yet), discard counter.
- Reset values: PC=RESET_PC, running=0, FIFO empty, counters 0; o_imem_req=0, o_valid=0, o_misaligned=0, o_instruction/o_pc=0.
- `running` sets on the first clock after reset release; o_imem_req never asserts before.
- o_imem_req = running & ~i_redirect & (fifo_count + outstanding − pop < FIFO_DEPTH), pop = o_valid & i_ready. Guarantees every response has a FIFO slot.
- o_imem_addr = PC. On req & gnt: PC += 4 (wrap mod 2^32), outstanding += 1.
- Ungranted request is not a commitment; address may change or req drop.
- On rvalid: outstanding −= 1; if discard > 0, drop data and discard −= 1; else push {addr-of-that-request, rdata}. Unit keeps a PC queue or computes response PC as PC − 4·(outstanding) at response time; either is acceptable if o_pc is exact.
- Pop on o_valid & i_ready.
- Redirect: FIFO flushed, no pop counted, PC ← i_redirect_pc, discard ← outstanding − rvalid (responses still in flight belong to old stream), response arriving in the redirect cycle dropped.
- Redirect during reset ignored.

## Timing
- Response pushed at rvalid edge; o_valid high the cycle after rvalid (1-cycle latency), if no redirect.
- Redirect cycle: req low; first request to target the next cycle.
- Sustained 1 instr/cycle with 1-cycle memory latency and i_ready high at FIFO_DEPTH=2 (pop credit makes req combinationally dependent on i_ready).
- o_instruction/o_pc stable while o_valid & ~i_ready.
- Simultaneous: push+pop legal at any count; redirect beats push/pop/grant; rvalid with discard>0 never reaches FIFO.
- Async reset mid-transaction: all state cleared; memory must tolerate abandoned responses.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with i_redirect_pc[1:0]≠0 sets o_misaligned (registered, held) and stops requests until next aligned redirect, which clears it. Not defined: i_redirect_pc[1:0] forced to 0, o_misaligned tied 0.

## Structure
- rv32_pkg: fetch_entry_t struct {pc, instr}, DEFAULT_RESET_PC, instruction-width constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count; flush overrides push/pop.

## Test plan
- Reset release, memory gnt always, 1-cycle latency, i_ready=1 -> first req addr 0x0 one cycle after release, o_pc sequence 0x0,0x4,0x8 one per cycle.
- i_ready=0 for 10 cycles -> at most 2 grants accepted, o_valid held, o_pc=0x0 stable, no FIFO overflow.
- Redirect to 0x100 with 2 outstanding, 3-cycle latency -> two old responses dropped, next o_pc=0x100 then 0x104.
- Redirect coincident with rvalid and pop -> FIFO empty next cycle, response dropped, req addr = target next cycle.
- gnt withheld 5 cycles -> o_imem_addr stable, PC unchanged, then normal stream resumes.
- FETCH_ALIGN_CHECK_EN: redirect to 0x102 -> o_misaligned=1, no req; redirect to 0x200 -> flag cleared, fetch at 0x200.
